alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 Parameter WIDTH SHALL be: WIDTH, default 32, datapath width; legal values are powers of two from 8 to 64; SW = log2(WIDTH).
REQ-002 clk  input  1  the single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operation request this cycle.
REQ-005 in_ready  output  1  unit can accept; combinational, = (state==IDLE) && !reset.
REQ-006 alucontrol  input  4  operation code: 0010 ADD, 0110 SUB, 0000 AND, 0001 OR, 1100 NOR, 0111 SLT, 0011 SLL, 1111 MUL.
REQ-007 sign  input  1  1 = signed semantics, 0 = unsigned.
REQ-008 a, b  input  WIDTH each  operands.
REQ-009 shamt  input  SW  shift amount for SLL.
REQ-010 out_valid  output  1  one-cycle pulse; the result outputs are valid.
REQ-011 result, result_hi  output  WIDTH each  result and MUL upper half.
REQ-012 zero, overflow, illegal  output  1 each  result==0, signed overflow, and unknown opcode flags.

Function
REQ-013 Accept SHALL occur on a rising edge where in_valid && in_ready; the operands, alucontrol, sign and shamt SHALL be captured at the accept.
REQ-014 The FSM SHALL have two states, IDLE and BUSY; accept of MUL -> BUSY; all other accepts stay in IDLE.
REQ-015 Single-cycle ops: accepted at edge ending cycle N -> out_valid=1 during N+1 only; back-to-back accepts SHALL give consecutive out_valid pulses.
REQ-016 ADD/SUB SHALL compute a+b and a-b, modulo 2^WIDTH; overflow = signed overflow when sign=1, else 0.
REQ-017 AND/OR/NOR SHALL be bitwise; SLL SHALL be b << shamt, zero-filled; overflow=0 for all four.
REQ-018 SLT SHALL give result 1 if a<b, else 0; the compare is signed when sign=1 and unsigned when sign=0; overflow=0.
REQ-019 MUL SHALL be an iterative shift-add over exactly WIDTH BUSY cycles on magnitudes, with a 6-bit iteration counter.
REQ-020 When sign=1, MUL SHALL apply two's-complement magnitudes and negate the 2*WIDTH product if the operand signs differ.
REQ-021 The MUL output split SHALL be {result_hi,result} = 2*WIDTH product; overflow=0.
REQ-022 MUL timing: accept at edge ending N -> BUSY during N+1..N+WIDTH -> IDLE with out_valid=1 during N+WIDTH+1.
REQ-023 in_ready SHALL be 1 again during N+WIDTH+1, so a new accept is allowed in that cycle.
REQ-024 For non-MUL ops, result_hi SHALL be 0.
REQ-025 Unknown alucontrol SHALL give result=0, result_hi=0, illegal=1, out_valid pulse with single-cycle latency, and no state change.
REQ-026 zero SHALL equal (result==0) and be registered together with result; it ignores result_hi.
REQ-027 The outputs SHALL be registered, holding their last values between pulses; only out_valid is a pulse.
REQ-028 in_valid while BUSY SHALL be ignored; the upstream holds the request until in_ready is 1.
REQ-029 There is no downstream backpressure; the consumer SHALL take the result in the out_valid cycle.

Reset
REQ-030 reset=1 at an edge SHALL set the state to IDLE and clear the counter and the internal product/operand registers.
REQ-031 The same reset edge SHALL set out_valid, result, result_hi, zero, overflow and illegal to 0.
REQ-032 Reset SHALL have priority over an accept and over an in-progress MUL: the MUL is aborted with no out_valid pulse for it.
REQ-033 While reset=1, in_ready SHALL be 0; in the first cycle after reset deasserts, in_ready SHALL be 1.

Verification
REQ-034 ADD, a=0x7FFFFFFF, b=1, sign=1 -> next cycle result=0x80000000, overflow=1, zero=0; the same with sign=0 -> overflow=0.
REQ-035 SLT, a=0xFFFFFFFF, b=1: sign=1 -> result=1; sign=0 -> result=0.
REQ-036 MUL, a=0xFFFFFFFD, b=7, sign=1 -> in_ready low exactly 32 cycles, then out_valid with result=0xFFFFFFEB, result_hi=0xFFFFFFFF.
REQ-037 Back-to-back: SUB 5-5, then NOR 0,0, then SLL b=1 shamt=31 -> three consecutive pulses: 0 with zero=1, then 0xFFFFFFFF, then 0x80000000.
REQ-038 Reset asserted on the 10th BUSY cycle of a MUL -> no out_valid for that MUL, all outputs 0, in_ready=1 the first cycle after release.
REQ-039 alucontrol=1010 -> next cycle out_valid=1, illegal=1, result=0, zero=1, state remains IDLE.

Source files
------------

// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle ADD/SUB/logic/SLT/SLL, and a WIDTH-cycle
// iterative shift-add multiplier producing a double-width product.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [3:0]                 alucontrol,
  input  logic                       sign,
  input  logic [WIDTH-1:0]           a,
  input  logic [WIDTH-1:0]           b,
  input  logic [$clog2(WIDTH)-1:0]   shamt,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           result,
  output logic [WIDTH-1:0]           result_hi,
  output logic                       zero,
  output logic                       overflow,
  output logic                       illegal
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state, state_nxt;

  logic                 accept;
  logic                 is_mul;
  logic                 last;
  logic [5:0]           cnt;
  logic [2*WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]     mplier;
  logic [2*WIDTH-1:0]   acc;
  logic                 neg;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_final;
  logic [WIDTH-1:0]     ma, mb;
  logic [WIDTH-1:0]     sum, diff;
  logic                 lt;
  logic [WIDTH-1:0]     op_res;
  logic                 op_ovf;
  logic                 op_ill;

  assign is_mul = (alucontrol == 4'b1111);
  assign accept = in_valid && in_ready;
  assign last   = (cnt == 6'(WIDTH-1));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (accept && is_mul) state_nxt = BUSY;
      BUSY: if (last)             state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready = (state == IDLE) && !reset;
  end

  // Single-cycle operation results
  always_comb begin
    sum    = a + b;
    diff   = a - b;
    lt     = sign ? ($signed(a) < $signed(b)) : (a < b);
    op_res = '0;
    op_ovf = 1'b0;
    op_ill = 1'b0;
    case (alucontrol)
      4'b0010: begin
        op_res = sum;
        op_ovf = sign && (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0110: begin
        op_res = diff;
        op_ovf = sign && (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      4'b0000: op_res = a & b;
      4'b0001: op_res = a | b;
      4'b1100: op_res = ~(a | b);
      4'b0111: op_res = {{(WIDTH-1){1'b0}}, lt};
      4'b0011: op_res = b << shamt;
      4'b1111: op_res = '0;
      default: op_ill = 1'b1;
    endcase
  end

  // Multiplier operand magnitudes and per-iteration accumulate
  always_comb begin
    ma         = (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
    mb         = (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;
    acc_step   = mplier[0] ? (acc + mcand) : acc;
    prod_final = neg ? (~acc_step + 1'b1) : acc_step;
  end

  // Datapath and registered outputs; the final MUL iteration's sum is folded
  // straight into the outputs so the pulse lands right after the last BUSY cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (accept) begin
        if (is_mul) begin
          mcand  <= {{WIDTH{1'b0}}, ma};
          mplier <= mb;
          acc    <= '0;
          neg    <= sign && (a[WIDTH-1] ^ b[WIDTH-1]);
          cnt    <= '0;
        end else begin
          result    <= op_res;
          result_hi <= '0;
          zero      <= (op_res == '0);
          overflow  <= op_ovf;
          illegal   <= op_ill;
          out_valid <= 1'b1;
        end
      end else if (state == BUSY) begin
        acc    <= acc_step;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 6'd1;
        if (last) begin
          result    <= prod_final[WIDTH-1:0];
          result_hi <= prod_final[2*WIDTH-1:WIDTH];
          zero      <= (prod_final[WIDTH-1:0] == '0);
          overflow  <= 1'b0;
          illegal   <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit (WIDTH=32): vector table for single-cycle ops,
// hand-written sequences for back-to-back, MUL latency and reset abort.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    alucontrol;
  logic          sign;
  logic [W-1:0]  a, b;
  logic [4:0]    shamt;
  logic          out_valid;
  logic [W-1:0]  result, result_hi;
  logic          zero, overflow, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .alucontrol(alucontrol), .sign(sign), .a(a), .b(b), .shamt(shamt),
    .out_valid(out_valid), .result(result), .result_hi(result_hi),
    .zero(zero), .overflow(overflow), .illegal(illegal)
  );

  typedef struct {
    logic [3:0]   op;
    logic         sg;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [4:0]   sh;
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    logic         il;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic sg,
                       input logic [W-1:0] va, input logic [W-1:0] vb, input logic [4:0] sh);
    in_valid   = v;
    alucontrol = op;
    sign       = sg;
    a          = va;
    b          = vb;
    shamt      = sh;
  endtask

  task automatic check_outs(input string tag, input logic [W-1:0] r, input logic [W-1:0] rh,
                            input logic z, input logic ov, input logic il);
    check({tag, ".out_valid"}, out_valid, 1'b1);
    check({tag, ".result"}, result, r);
    check({tag, ".result_hi"}, result_hi, rh);
    check({tag, ".zero"}, zero, z);
    check({tag, ".overflow"}, overflow, ov);
    check({tag, ".illegal"}, illegal, il);
  endtask

  // MUL with in_valid held high on an ADD during BUSY: the ADD must be ignored
  // until in_ready returns, then accepted in the result cycle.
  task automatic run_mul(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic sg, input logic [2*W-1:0] exp);
    int busy;
    int early;
    drive(1'b1, 4'b1111, sg, va, vb, 5'd0);
    step();
    drive(1'b1, 4'b0010, 1'b0, 32'd10, 32'd20, 5'd0);
    busy  = 0;
    early = 0;
    while (!in_ready && busy < 100) begin
      if (out_valid) early++;
      busy++;
      step();
    end
    check({tag, ".busy_cycles"}, busy, W);
    check({tag, ".early_pulse"}, early, 0);
    check_outs(tag, exp[W-1:0], exp[2*W-1:W], exp[W-1:0] == '0, 1'b0, 1'b0);
    step();
    drive(1'b0, 4'b0010, 1'b0, '0, '0, 5'd0);
    check_outs({tag, ".add_after"}, 32'd30, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    vecs[0]  = '{4'b0010, 1'b1, 32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{4'b0010, 1'b0, 32'h7FFF_FFFF, 32'h1,         5'd0,  32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{4'b0010, 1'b0, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b1, 1'b0, 1'b0};
    vecs[3]  = '{4'b0110, 1'b1, 32'h8000_0000, 32'h1,         5'd0,  32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{4'b0110, 1'b1, 32'd5,         32'd5,         5'd0,  32'h0,         1'b1, 1'b0, 1'b0};
    vecs[5]  = '{4'b0000, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0,  32'hF000_F000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{4'b0001, 1'b0, 32'h0F0F_0000, 32'h0000_00FF, 5'd0,  32'h0F0F_00FF, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{4'b1100, 1'b0, 32'h0,         32'h0,         5'd0,  32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{4'b0111, 1'b1, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h1,         1'b0, 1'b0, 1'b0};
    vecs[9]  = '{4'b0111, 1'b0, 32'hFFFF_FFFF, 32'h1,         5'd0,  32'h0,         1'b1, 1'b0, 1'b0};
    vecs[10] = '{4'b0011, 1'b0, 32'h0,         32'h1,         5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{4'b0011, 1'b0, 32'h0,         32'h0000_00F3, 5'd4,  32'h0000_0F30, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{4'b1010, 1'b0, 32'd5,         32'd3,         5'd0,  32'h0,         1'b1, 1'b0, 1'b1};

    reset = 1'b1;
    drive(1'b0, 4'b0010, 1'b0, '0, '0, 5'd0);
    step();
    step();
    check("rst.in_ready", in_ready, 1'b0);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.result", result, 32'd0);
    reset = 1'b0;
    #1;
    check("rst.release_ready", in_ready, 1'b1);

    for (int i = 0; i < 13; i++) begin
      drive(1'b1, vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b, vecs[i].sh);
      step();
      drive(1'b0, 4'b0010, 1'b0, '0, '0, 5'd0);
      check_outs($sformatf("vec%0d", i), vecs[i].res, 32'd0, vecs[i].z, vecs[i].ov, vecs[i].il);
      check($sformatf("vec%0d.in_ready", i), in_ready, 1'b1);
      step();
      check($sformatf("vec%0d.pulse_end", i), out_valid, 1'b0);
      check($sformatf("vec%0d.hold", i), result, vecs[i].res);
    end

    // back-to-back accepts give consecutive pulses
    drive(1'b1, 4'b0110, 1'b0, 32'd5, 32'd5, 5'd0);
    step();
    check_outs("b2b0", 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 4'b1100, 1'b0, 32'd0, 32'd0, 5'd0);
    step();
    check_outs("b2b1", 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 4'b0011, 1'b0, 32'd0, 32'd1, 5'd31);
    step();
    drive(1'b0, 4'b0010, 1'b0, '0, '0, 5'd0);
    check_outs("b2b2", 32'h8000_0000, 32'h0, 1'b0, 1'b0, 1'b0);
    step();
    check("b2b.end", out_valid, 1'b0);

    run_mul("mul_s", 32'hFFFF_FFFD, 32'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFEB);
    run_mul("mul_u", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
    run_mul("mul_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
    run_mul("mul_hi", 32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
    run_mul("mul_neg", 32'd6, 32'hFFFF_FFFE, 1'b1, 64'hFFFF_FFFF_FFFF_FFF4);

    // make outputs nonzero before the abort so clearing is observable
    drive(1'b1, 4'b0110, 1'b1, 32'h8000_0000, 32'h1, 5'd0);
    step();
    drive(1'b1, 4'b1111, 1'b1, 32'hFFFF_FFFD, 32'd7, 5'd0);
    step();
    drive(1'b0, 4'b0010, 1'b0, '0, '0, 5'd0);
    for (int i = 0; i < 9; i++) step();
    check("abort.busy", in_ready, 1'b0);
    reset = 1'b1;
    #1;
    check("abort.rst_ready", in_ready, 1'b0);
    step();
    reset = 1'b0;
    check("abort.out_valid", out_valid, 1'b0);
    check("abort.result", result, 32'd0);
    check("abort.result_hi", result_hi, 32'd0);
    check("abort.zero", zero, 1'b0);
    check("abort.overflow", overflow, 1'b0);
    check("abort.illegal", illegal, 1'b0);
    #1;
    check("abort.release_ready", in_ready, 1'b1);
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
        step();
        if (out_valid) pulses++;
      end
      check("abort.no_pulse", pulses, 0);
    end

    // unit is usable again after the abort
    drive(1'b1, 4'b0010, 1'b0, 32'd2, 32'd3, 5'd0);
    step();
    drive(1'b0, 4'b0010, 1'b0, '0, '0, 5'd0);
    check_outs("post_abort", 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
